// File: rtl/pending_tracker_pkg.sv
// Shared types and helpers for the four-channel pending request tracker.
package pending_tracker_pkg;

  localparam int NUM_CH      = 4;
  localparam int IDX_W       = 2;
  localparam int DEF_COUNT_W = 3;

  typedef logic [DEF_COUNT_W-1:0] count_t;

  // Lowest set bit wins, matching the downstream low-priority encoder.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_CH-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pending_request_tracker_4_channel_event_counter.sv
// One request channel: event detection plus a saturating pending-event counter.
module channel_event_counter
  import pending_tracker_pkg::*;
#(
  parameter int COUNT_W   = DEF_COUNT_W,
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic req_i,
  input  logic sel_i,
  output logic pending_o,
  output logic lost_o
);

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  logic               req_q;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;
  logic               evt;

  always_comb begin
    evt     = EDGE_MODE ? (req_i & ~req_q) : req_i;
    count_d = count_q;
    lost_o  = 1'b0;
    // A simultaneous event and accept cancel out before saturation is considered.
    if (evt && sel_i) begin
      count_d = count_q;
    end else if (evt && (count_q == CNT_MAX)) begin
      lost_o  = 1'b1;
    end else if (evt) begin
      count_d = count_q + 1'b1;
    end else if (sel_i) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      req_q   <= 1'b0;
      count_q <= '0;
    end else begin
      req_q   <= req_i;
      count_q <= count_d;
    end
  end

  assign pending_o = |count_q;

endmodule

// File: rtl/pending_request_tracker_4.sv
// Captures events on four request lines and presents the lowest pending channel
// through a valid/index/ack interface; pending flags feed the priority encoder.
module pending_request_tracker_4
  import pending_tracker_pkg::*;
#(
  parameter int COUNT_W   = DEF_COUNT_W,
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic             Clock_In,
  input  logic             Reset_N_In,
  input  logic             Req_0_In,
  input  logic             Req_1_In,
  input  logic             Req_2_In,
  input  logic             Req_3_In,
  input  logic             Ack_In,
  input  logic             Clear_Overflow_In,
  output logic             Pending_0_Out,
  output logic             Pending_1_Out,
  output logic             Pending_2_Out,
  output logic             Pending_3_Out,
  output logic             Valid_Out,
  output logic [IDX_W-1:0] Index_Out,
  output logic             Overflow_Out
);

  logic [NUM_CH-1:0] req_w;
  logic [NUM_CH-1:0] sel_w;
  logic [NUM_CH-1:0] pend_w;
  logic [NUM_CH-1:0] lost_w;
  logic              acc;
  logic              ovf_q;
  logic              ovf_d;

  assign req_w = {Req_3_In, Req_2_In, Req_1_In, Req_0_In};

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    channel_event_counter #(
      .COUNT_W   (COUNT_W),
      .EDGE_MODE (EDGE_MODE)
    ) u_cnt (
      .clk_i     (Clock_In),
      .rst_n_i   (Reset_N_In),
      .req_i     (req_w[ch]),
      .sel_i     (sel_w[ch]),
      .pending_o (pend_w[ch]),
      .lost_o    (lost_w[ch])
    );
  end

  // Outputs decode only registered counts, so Req/Ack never reach them combinationally.
  always_comb begin
    Valid_Out = |pend_w;
    Index_Out = Valid_Out ? lowest_set(pend_w) : '0;
    acc       = Valid_Out & Ack_In;
    sel_w     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_w[i] = acc & (Index_Out == IDX_W'(i));
    end
  end

  assign Pending_0_Out = pend_w[0];
  assign Pending_1_Out = pend_w[1];
  assign Pending_2_Out = pend_w[2];
  assign Pending_3_Out = pend_w[3];

  // A loss in the same cycle as a clear keeps the flag set.
  assign ovf_d = (|lost_w) | (ovf_q & ~Clear_Overflow_In);

  always_ff @(posedge Clock_In) begin
    if (!Reset_N_In) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign Overflow_Out = ovf_q;

endmodule

// File: tb/tb_pending_request_tracker_4.sv
// Directed bench for pending_request_tracker_4: edge-mode and level-mode instances share stimulus.
module tb_pending_request_tracker_4;
  import pending_tracker_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1, req2, req3;
  logic       ack, clr;
  logic       p0_e, p1_e, p2_e, p3_e, v_e, o_e;
  logic [1:0] i_e;
  logic       p0_l, p1_l, p2_l, p3_l, v_l, o_l;
  logic [1:0] i_l;
  int         nvec = 0;
  int         nerr = 0;

  always #5 clk = ~clk;

  pending_request_tracker_4 #(.COUNT_W(3), .EDGE_MODE(1'b1)) dut (
    .Clock_In(clk), .Reset_N_In(rst_n),
    .Req_0_In(req0), .Req_1_In(req1), .Req_2_In(req2), .Req_3_In(req3),
    .Ack_In(ack), .Clear_Overflow_In(clr),
    .Pending_0_Out(p0_e), .Pending_1_Out(p1_e), .Pending_2_Out(p2_e), .Pending_3_Out(p3_e),
    .Valid_Out(v_e), .Index_Out(i_e), .Overflow_Out(o_e)
  );

  pending_request_tracker_4 #(.COUNT_W(3), .EDGE_MODE(1'b0)) dut_lvl (
    .Clock_In(clk), .Reset_N_In(rst_n),
    .Req_0_In(req0), .Req_1_In(req1), .Req_2_In(req2), .Req_3_In(req3),
    .Ack_In(ack), .Clear_Overflow_In(clr),
    .Pending_0_Out(p0_l), .Pending_1_Out(p1_l), .Pending_2_Out(p2_l), .Pending_3_Out(p3_l),
    .Valid_Out(v_l), .Index_Out(i_l), .Overflow_Out(o_l)
  );

  // Status word: {overflow, valid, index[1:0], pending[3:0]}
  function automatic logic [7:0] st_e();
    return {o_e, v_e, i_e, p3_e, p2_e, p1_e, p0_e};
  endfunction

  function automatic logic [7:0] st_l();
    return {o_l, v_l, i_l, p3_l, p2_l, p1_l, p0_l};
  endfunction

  function automatic logic [7:0] exp_st(input logic ovf, input logic vld,
                                        input logic [1:0] idx, input logic [3:0] pend);
    return {ovf, vld, idx, pend};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got ovf/vld/idx/pend=%b_%b_%b_%b want %b_%b_%b_%b", tag,
               obs[7], obs[6], obs[5:4], obs[3:0], exp[7], exp[6], exp[5:4], exp[3:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic pulse0();
    req0 = 1'b1; tick();
    req0 = 1'b0; tick();
  endtask

  initial begin
    rst_n = 1'b0; ack = 1'b0; clr = 1'b0;
    req0 = 1'b1; req1 = 1'b1; req2 = 1'b1; req3 = 1'b1;

    // Reset held with all requests high
    tick(); tick();
    check("reset_hold", st_e(), exp_st(1'b0, 1'b0, 2'd0, 4'b0000));
    rst_n = 1'b1;
    tick();
    req0 = 1'b0; req1 = 1'b0; req2 = 1'b0; req3 = 1'b0;
    check("release_all", st_e(), exp_st(1'b0, 1'b1, 2'd0, 4'b1111));
    do_ack(); check("rel_ack1", st_e(), exp_st(1'b0, 1'b1, 2'd1, 4'b1110));
    do_ack(); check("rel_ack2", st_e(), exp_st(1'b0, 1'b1, 2'd2, 4'b1100));
    do_ack(); check("rel_ack3", st_e(), exp_st(1'b0, 1'b1, 2'd3, 4'b1000));
    do_ack(); check("rel_ack4", st_e(), exp_st(1'b0, 1'b0, 2'd0, 4'b0000));

    // Priority: Req_2 then Req_1
    req2 = 1'b1;
    #1 check("no_comb_path", st_e(), exp_st(1'b0, 1'b0, 2'd0, 4'b0000));
    tick();
    check("prio_req2", st_e(), exp_st(1'b0, 1'b1, 2'd2, 4'b0100));
    req2 = 1'b0; req1 = 1'b1;
    tick();
    req1 = 1'b0;
    check("prio_req1", st_e(), exp_st(1'b0, 1'b1, 2'd1, 4'b0110));
    do_ack(); check("prio_ack1", st_e(), exp_st(1'b0, 1'b1, 2'd2, 4'b0100));
    do_ack(); check("prio_ack2", st_e(), exp_st(1'b0, 1'b0, 2'd0, 4'b0000));

    // Same-cycle event and ack on channel 3
    req3 = 1'b1; tick();
    req3 = 1'b0; tick();
    check("ch3_pending", st_e(), exp_st(1'b0, 1'b1, 2'd3, 4'b1000));
    req3 = 1'b1; ack = 1'b1; tick();
    req3 = 1'b0; ack = 1'b0;
    check("ch3_evt_ack", st_e(), exp_st(1'b0, 1'b1, 2'd3, 4'b1000));
    do_ack(); check("ch3_drain", st_e(), exp_st(1'b0, 1'b0, 2'd0, 4'b0000));

    // Saturation on channel 0
    for (int i = 0; i < 7; i++) pulse0();
    check("sat_7edges", st_e(), exp_st(1'b0, 1'b1, 2'd0, 4'b0001));
    pulse0();
    check("sat_8th_ovf", st_e(), exp_st(1'b1, 1'b1, 2'd0, 4'b0001));
    for (int i = 0; i < 6; i++) do_ack();
    check("sat_6acks", st_e(), exp_st(1'b1, 1'b1, 2'd0, 4'b0001));
    do_ack();
    check("sat_7acks", st_e(), exp_st(1'b1, 1'b0, 2'd0, 4'b0000));
    clr = 1'b1; tick(); clr = 1'b0;
    check("ovf_clear", st_e(), exp_st(1'b0, 1'b0, 2'd0, 4'b0000));

    // Held level on Req_1 for 10 cycles; clear collides with a loss on the last one
    rst_n = 1'b0; tick();
    check("lvl_reset", st_l(), exp_st(1'b0, 1'b0, 2'd0, 4'b0000));
    rst_n = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    clr = 1'b1; tick();
    clr = 1'b0; req1 = 1'b0;
    check("held_edge", st_e(), exp_st(1'b0, 1'b1, 2'd1, 4'b0010));
    check("held_level", st_l(), exp_st(1'b1, 1'b1, 2'd1, 4'b0010));
    do_ack();
    check("held_edge_ack", st_e(), exp_st(1'b0, 1'b0, 2'd0, 4'b0000));
    for (int i = 0; i < 5; i++) do_ack();
    check("held_level_6acks", st_l(), exp_st(1'b1, 1'b1, 2'd1, 4'b0010));
    do_ack();
    check("held_level_7acks", st_l(), exp_st(1'b1, 1'b0, 2'd0, 4'b0000));
    clr = 1'b1; tick(); clr = 1'b0;
    check("held_level_clr", st_l(), exp_st(1'b0, 1'b0, 2'd0, 4'b0000));

    // Reset mid-stream with counts {3,0,2,1}
    req0 = 1'b1; req2 = 1'b1; req3 = 1'b1; tick();
    req0 = 1'b0; req2 = 1'b0; req3 = 1'b0; tick();
    req0 = 1'b1; req2 = 1'b1; tick();
    req0 = 1'b0; req2 = 1'b0; tick();
    pulse0();
    check("mid_counts", st_e(), exp_st(1'b0, 1'b1, 2'd0, 4'b1101));
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("mid_reset", st_e(), exp_st(1'b0, 1'b0, 2'd0, 4'b0000));
    do_ack();
    check("ack_idle", st_e(), exp_st(1'b0, 1'b0, 2'd0, 4'b0000));
    req2 = 1'b1; tick(); req2 = 1'b0;
    check("post_reset_evt", st_e(), exp_st(1'b0, 1'b1, 2'd2, 4'b0100));
    do_ack();
    check("post_reset_ack", st_e(), exp_st(1'b0, 1'b0, 2'd0, 4'b0000));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
